// File: rtl/bitslice_bram_mm.sv
// bitslice_bram_mm: bit-sliced dual-port block RAM holding NUM_ROWS bit-plane rows
// of ROW_BITS bits each. It has a configurable read pipeline and a column-fill engine.
//
// Ports
//   clk, reset             rising-edge clock; asynchronous active-high reset
//   a_* / b_*              two access ports:
//                            en    - access request
//                            we    - write, qualified by en
//                            mode  - 0 = column, 1 = row
//                            addr  - column index, or {row, word} in row mode
//                            din   - write data
//                            dout  - read data
//                            valid - dout strobe
//   init_start             start a fill of every column with init_pattern
//   init_pattern           column pattern captured at start
//   init_busy, init_done   fill in progress / one-cycle completion pulse
//   fill_state_dbg         fill engine state, for observation
//
// Handshake: an access with en=1 sampled at a rising edge produces valid=1
// READ_LAT cycles later. There is no backpressure. dout only changes when valid=1.
// Port B requests are silently discarded while init_busy=1.
module bitslice_bram_mm #(
  parameter int NUM_ROWS = 16,
  parameter int ROW_BITS = 160,
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_en,
  input  logic                a_we,
  input  logic                a_mode,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [NUM_ROWS-1:0] a_din,
  output logic [NUM_ROWS-1:0] a_dout,
  output logic                a_valid,
  input  logic                b_en,
  input  logic                b_we,
  input  logic                b_mode,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [NUM_ROWS-1:0] b_din,
  output logic [NUM_ROWS-1:0] b_dout,
  output logic                b_valid,
  input  logic                init_start,
  input  logic [NUM_ROWS-1:0] init_pattern,
  output logic                init_busy,
  output logic                init_done,
  output logic [1:0]          fill_state_dbg
);

  localparam int WORDS = ROW_BITS / NUM_ROWS;
  localparam int WI_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RI_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CB_W  = $clog2(ROW_BITS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_DONE = 2'd2} fill_state_t;

  // Decoded address. In column mode only col is used. In row mode row and base are used.
  // base is the bit offset of the word inside the row.
  typedef struct packed {
    logic            ok;
    logic [CB_W-1:0] col;
    logic [RI_W-1:0] row;
    logic [CB_W-1:0] base;
  } acc_t;

  logic [ROW_BITS-1:0] mem_q [NUM_ROWS];

  fill_state_t         state_q, state_d;
  logic [CB_W-1:0]     col_q, col_d;
  logic [NUM_ROWS-1:0] pat_q, pat_d;
  logic                fill_busy;

  acc_t                a_dec, b_dec;
  logic                b_acc;
  logic [NUM_ROWS-1:0] a_rdata, b_rdata;

  logic                a_v1_q, b_v1_q;
  logic [NUM_ROWS-1:0] a_d1_q, b_d1_q;

  function automatic acc_t decode(input logic mode, input logic [ADDR_W-1:0] addr);
    acc_t d;
    logic [WI_W-1:0] word;
    d      = '0;
    word   = addr[WI_W-1:0];
    d.col  = addr[CB_W-1:0];
    d.row  = addr[WI_W +: RI_W];
    d.base = CB_W'(32'(word) * NUM_ROWS);
    if (!mode) d.ok = (addr < ADDR_W'(ROW_BITS));
    else       d.ok = (32'(word) < WORDS) && (32'(d.row) < NUM_ROWS);
    return d;
  endfunction

  function automatic logic [NUM_ROWS-1:0] rd_data(input logic mode, input acc_t d);
    logic [NUM_ROWS-1:0] r;
    r = '0;
    if (d.ok) begin
      if (mode) r = mem_q[d.row][d.base +: NUM_ROWS];
      else for (int i = 0; i < NUM_ROWS; i++) r[i] = mem_q[i][d.col];
    end
    return r;
  endfunction

  assign a_dec     = decode(a_mode, a_addr);
  assign b_dec     = decode(b_mode, b_addr);
  assign fill_busy = (state_q == S_FILL);
  assign b_acc     = b_en & ~fill_busy;

  // Reads return the pre-write contents, so a cross-port write in the same cycle is
  // not visible. A port's own write returns the written data; a dropped write returns 0.
  always_comb begin
    a_rdata = '0;
    if (a_we) begin
      if (a_dec.ok) a_rdata = a_din;
    end else begin
      a_rdata = rd_data(a_mode, a_dec);
    end
  end

  always_comb begin
    b_rdata = '0;
    if (b_we) begin
      if (b_dec.ok) b_rdata = b_din;
    end else begin
      b_rdata = rd_data(b_mode, b_dec);
    end
  end

  // Fill engine
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      pat_q   <= pat_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    pat_d          = pat_q;
    init_busy      = 1'b0;
    init_done      = 1'b0;
    fill_state_dbg = state_q;
    case (state_q)
      S_IDLE: begin
        if (init_start) begin
          pat_d   = init_pattern;
          col_d   = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        init_busy = 1'b1;
        if (col_q == CB_W'(ROW_BITS - 1)) state_d = S_DONE;
        else                              col_d   = col_q + 1'b1;
      end
      S_DONE: begin
        init_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage is never reset. Later non-blocking writes override earlier ones bit by bit.
  // The priority is therefore engine < port B < port A.
  always_ff @(posedge clk) begin
    if (fill_busy) begin
      for (int i = 0; i < NUM_ROWS; i++) mem_q[i][col_q] <= pat_q[i];
    end
    if (b_acc && b_we && b_dec.ok) begin
      if (b_mode) mem_q[b_dec.row][b_dec.base +: NUM_ROWS] <= b_din;
      else for (int i = 0; i < NUM_ROWS; i++) mem_q[i][b_dec.col] <= b_din[i];
    end
    if (a_en && a_we && a_dec.ok) begin
      if (a_mode) mem_q[a_dec.row][a_dec.base +: NUM_ROWS] <= a_din;
      else for (int i = 0; i < NUM_ROWS; i++) mem_q[i][a_dec.col] <= a_din[i];
    end
  end

  // Read pipeline, first stage. Data registers only load with a valid access so dout holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_v1_q <= 1'b0;
      b_v1_q <= 1'b0;
      a_d1_q <= '0;
      b_d1_q <= '0;
    end else begin
      a_v1_q <= a_en;
      b_v1_q <= b_acc;
      if (a_en)  a_d1_q <= a_rdata;
      if (b_acc) b_d1_q <= b_rdata;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic                a_v2_q, b_v2_q;
    logic [NUM_ROWS-1:0] a_d2_q, b_d2_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_v2_q <= 1'b0;
        b_v2_q <= 1'b0;
        a_d2_q <= '0;
        b_d2_q <= '0;
      end else begin
        a_v2_q <= a_v1_q;
        b_v2_q <= b_v1_q;
        if (a_v1_q) a_d2_q <= a_d1_q;
        if (b_v1_q) b_d2_q <= b_d1_q;
      end
    end
    assign a_valid = a_v2_q;
    assign b_valid = b_v2_q;
    assign a_dout  = a_d2_q;
    assign b_dout  = b_d2_q;
  end else begin : g_lat1
    assign a_valid = a_v1_q;
    assign b_valid = b_v1_q;
    assign a_dout  = a_d1_q;
    assign b_dout  = b_d1_q;
  end

endmodule

// File: doc/bitslice_bram_mm.md
Name: bitslice_bram_mm

Overview:
- Parametrised successor to the team's bit-sliced dual-port block RAM. Storage is NUM_ROWS bit-plane rows of ROW_BITS bits each.
- Each of two ports chooses per access between:
  - column mode: one bit from every row at a column index;
  - row mode: a NUM_ROWS-wide word inside one row.
- Adds a configurable read pipeline and a column-fill engine for bulk initialisation of bit-slice operand storage in the bit-serial processing array.

Parameters:
- NUM_ROWS, 16, number of bit-plane rows; also the port data width.
- ROW_BITS, 160, bits per row; must be a multiple of NUM_ROWS.
- ADDR_W, 10, address width; must be at least clog2(ROW_BITS) and at least clog2(NUM_ROWS)+clog2(ROW_BITS/NUM_ROWS).
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- a_en  in  1  port A access request.
- a_we  in  1  port A write, qualified by a_en.
- a_mode  in  1  0 = column mode, 1 = row mode.
- a_addr  in  ADDR_W  column mode: column index; row mode: {row index (upper clog2(NUM_ROWS) bits), word index (low clog2(ROW_BITS/NUM_ROWS) bits)}.
- a_din  in  NUM_ROWS  write data; column mode: bit i goes to row i.
- a_dout  out  NUM_ROWS  read data.
- a_valid  out  1  a_dout valid strobe.
- b_en, b_we, b_mode, b_addr, b_din, b_dout, b_valid: same as the port A ports, for port B.
- init_start  in  1  start the fill engine.
- init_pattern  in  NUM_ROWS  column pattern written to every column.
- init_busy  out  1  fill engine active.
- init_done  out  1  one-cycle pulse when the fill completes.

Behaviour:
- Reset, asynchronous active-high:
  - a_dout, b_dout, a_valid, b_valid, init_busy, init_done all go to 0.
  - Fill engine returns to IDLE and its column counter to 0.
  - Array contents are NOT cleared.
- Column mode:
  - Write: row[i][addr] <= din[i] for i = 0..NUM_ROWS-1.
  - Read: dout[i] = row[i][addr].
- Row mode:
  - Write: row[r][w*NUM_ROWS +: NUM_ROWS] <= din.
  - Read returns that same slice.
- Out-of-range addresses, i.e. column >= ROW_BITS, row word index >= ROW_BITS/NUM_ROWS, or row index >= NUM_ROWS:
  - writes are dropped;
  - reads return 0 with valid still asserted.
- Read latency:
  - an access with en=1 in cycle N (read or write) gives valid=1 and dout in cycle N+READ_LAT;
  - dout holds its value while valid=0.
- Write-first on the same port: a write access returns the newly written data on dout.
- Cross-port read of a bit written by the other port in the same cycle returns the old value.
- Simultaneous writes to the same physical bit from A and B: A wins, bit by bit. Mixed-mode overlaps resolve per bit.
- Fill engine states and transitions:
  - IDLE: init_start=1 captures init_pattern, clears the column counter col=0, sets init_busy=1, moves to FILL.
  - FILL: each cycle writes column col with the captured pattern, col++. After col=ROW_BITS-1 is written, moves to DONE.
  - DONE: init_done=1 for one cycle, init_busy=0, returns to IDLE.
  - init_start is ignored outside IDLE.
- While init_busy=1, port B requests are ignored: no write, no b_valid.
- Port A stays fully functional during a fill. A port A write to the column the engine writes in the same cycle wins over the engine.
- Fill takes exactly ROW_BITS cycles of init_busy. With defaults: init_start sampled at edge N, init_busy high N+1..N+160, init_done at N+161 edge.
- Reset asserted mid-fill aborts immediately:
  - columns already written keep the pattern;
  - no init_done pulse.

Test Plan:
1. Column write A addr 5, din 16'hA5C3, then column read B addr 5 -> b_valid one cycle later (READ_LAT=1) with b_dout=16'hA5C3. Row-mode read B of row 0 word 0 -> bit5=1, other bits 0 after a prior fill with 0.
2. Row write A row 3 word 9 din 16'hFFFF, then column reads of cols 144..159 -> each returns 16'h0008; col 143 -> 16'h0000.
3. Same-cycle writes A col 7 din 16'h00FF and B col 7 din 16'hFF00, then read -> 16'h00FF. A row-mode read of address 4'hF/word 10 (out of range) -> dout 0, valid 1.
4. init_start with init_pattern 16'h1234 -> init_busy high exactly 160 cycles, init_done single pulse. Every column reads 16'h1234; a B write issued during busy is dropped and produces no b_valid.
5. Reset asserted at fill cycle 50 -> all outputs 0, no init_done. Cols 0..49 read 16'h1234, col 50 and above keep old contents.
6. READ_LAT=2 build: back-to-back reads of cols 0,1,2 every cycle -> valid on cycles +2,+3,+4 with matching data in order.
